// File: rtl/fp_wb_scheduler_if.sv
// Bus between the FP issue/execute/load stages and the float writeback
// scheduler: issue hazard check, two producer handshakes, register-file write
// port and the pending scoreboard.
interface fp_wb_scheduler_if #(
  parameter int DW = 32
);
  // issue stage
  logic          iss_valid;
  logic [4:0]    iss_rd;
  logic [4:0]    iss_rs;
  logic [4:0]    iss_rt;
  logic          iss_rs_use;
  logic          iss_rt_use;
  logic          iss_stall;
  // FPU producer
  logic          fpu_valid;
  logic [4:0]    fpu_rd;
  logic [DW-1:0] fpu_data;
  logic          fpu_ready;
  // load producer
  logic          mem_valid;
  logic [4:0]    mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  // regfile_float write port and scoreboard view
  logic          regwrite_float;
  logic [4:0]    wa3;
  logic [DW-1:0] wd3;
  logic [31:0]   pending;

  // Scheduler side
  modport slave (
    input  iss_valid, iss_rd, iss_rs, iss_rt, iss_rs_use, iss_rt_use,
    input  fpu_valid, fpu_rd, fpu_data,
    input  mem_valid, mem_rd, mem_data,
    output iss_stall, fpu_ready, mem_ready,
    output regwrite_float, wa3, wd3, pending
  );

  // Pipeline / producer side
  modport master (
    output iss_valid, iss_rd, iss_rs, iss_rt, iss_rs_use, iss_rt_use,
    output fpu_valid, fpu_rd, fpu_data,
    output mem_valid, mem_rd, mem_data,
    input  iss_stall, fpu_ready, mem_ready,
    input  regwrite_float, wa3, wd3, pending
  );
endinterface

// File: rtl/fp_wb_scheduler.sv
// Float register-file writeback scheduler. Arbitrates the single write port
// between the FPU and the load path (round-robin or mem-priority), registers
// the winning result for one cycle, and tracks in-flight float destinations
// so the issue stage stalls on RAW/WAW hazards. No bypass: a register stays
// pending until the edge at which regfile_float actually commits it.
module fp_wb_scheduler #(
  parameter bit RR_EN = 1'b1,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              reset,
  fp_wb_scheduler_if.slave bus
);

  localparam logic SRC_MEM = 1'b0;
  localparam logic SRC_FPU = 1'b1;

  logic          last;      // producer granted on the most recent transfer
  logic          mem_gnt;
  logic          fpu_gnt;
  logic          xfer;
  logic [4:0]    sel_rd;
  logic [DW-1:0] sel_data;

  logic          wr_q;
  logic [4:0]    wa_q;
  logic [DW-1:0] wd_q;
  logic [31:0]   pend_q;
  logic [31:0]   pend_nxt;
  logic          stall;
  logic          accept;

  // Grant selection: a lone requester always wins; on a tie either alternate
  // against the last winner or let the load path win outright.
  always_comb begin
    mem_gnt = 1'b0;
    fpu_gnt = 1'b0;
    if (bus.mem_valid && bus.fpu_valid) begin
      if (RR_EN && (last == SRC_MEM)) fpu_gnt = 1'b1;
      else                            mem_gnt = 1'b1;
    end else begin
      mem_gnt = bus.mem_valid;
      fpu_gnt = bus.fpu_valid;
    end
  end

  assign xfer     = mem_gnt | fpu_gnt;
  assign sel_rd   = mem_gnt ? bus.mem_rd   : bus.fpu_rd;
  assign sel_data = mem_gnt ? bus.mem_data : bus.fpu_data;

  assign bus.mem_ready = mem_gnt;
  assign bus.fpu_ready = fpu_gnt;

  // Writeback register: capture the winner; f0 is accepted but never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      last <= SRC_FPU;
    end else if (xfer) begin
      wr_q <= (sel_rd != 5'd0);
      wa_q <= sel_rd;
      wd_q <= sel_data;
      last <= fpu_gnt ? SRC_FPU : SRC_MEM;
    end else begin
      wr_q <= 1'b0;
    end
  end

  assign bus.regwrite_float = wr_q;
  assign bus.wa3            = wa_q;
  assign bus.wd3            = wd_q;

  // Hazard check against the registered scoreboard only (no bypass).
  assign stall = bus.iss_valid &&
                 ((bus.iss_rs_use && pend_q[bus.iss_rs]) ||
                  (bus.iss_rt_use && pend_q[bus.iss_rt]) ||
                  pend_q[bus.iss_rd]);
  assign accept        = bus.iss_valid && !stall;
  assign bus.iss_stall = stall;

  // Scoreboard next state: clear on commit, then set on issue so set wins.
  always_comb begin
    pend_nxt = pend_q;
    if (wr_q) pend_nxt[wa_q] = 1'b0;
    if (accept && (bus.iss_rd != 5'd0)) pend_nxt[bus.iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_nxt;
  end

  assign bus.pending = pend_q;

endmodule
